// File: rtl/monitoreo_multicanal.sv
// monitoreo_multicanal: N-channel temperature supervisor.
// Each channel classifies its samples (frio/normal/calor) and runs its own
// NORMAL/BAJO/ALTO/ALERTA state machine with persistence before alert and
// before recovery. Outputs are a pure decode of the per-channel registers.
// Optional build macro: MONITOREO_HISTERESIS_EN narrows the recovery zone
// by HIST on each side and gates BAJO/ALTO -> NORMAL with the same margins.
module monitoreo_multicanal #(
    parameter int N_CH   = 4,
    parameter int W      = 10,
    parameter int T_MIN  = 180,
    parameter int T_MAX  = 259,
    parameter int N_PERS = 6,
    parameter int N_RECU = 1,
    parameter int HIST   = 5,
    localparam int CNT_MAX = (N_PERS > N_RECU) ? N_PERS : N_RECU,
    localparam int CW      = $clog2(CNT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*W-1:0]    temp_entrada,
    input  logic [N_CH-1:0]      valido,
    input  logic [N_CH-1:0]      canal_en,
    input  logic                 borrar_sticky,
    output logic [2*N_CH-1:0]    estado_actual,
    output logic [N_CH*CW-1:0]   contador_salida,
    output logic [N_CH-1:0]      alerta,
    output logic [N_CH-1:0]      calefactor,
    output logic [N_CH-1:0]      ventilador,
    output logic                 alerta_global,
    output logic                 alerta_sticky
);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        BAJO   = 2'b01,
        ALTO   = 2'b10,
        ALERTA = 2'b11
    } estado_t;

    localparam logic [W-1:0]  T_MIN_C  = W'(T_MIN);
    localparam logic [W-1:0]  T_MAX_C  = W'(T_MAX);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] PERS_C   = CW'(N_PERS);
    localparam logic [CW-1:0] RECU_C   = CW'(N_RECU);
`ifdef MONITOREO_HISTERESIS_EN
    localparam logic [W-1:0]  REC_LO_C = W'(T_MIN + HIST);
    localparam logic [W-1:0]  REC_HI_C = W'(T_MAX - HIST);
`endif

    // One bit per channel: that channel moves into ALERTA at the coming edge.
    logic [N_CH-1:0] entra_alerta;

    for (genvar i = 0; i < N_CH; i++) begin : g_canal
        estado_t       estado_q, estado_d;
        logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
        logic          dir_q, dir_d;
        logic [W-1:0]  t;
        logic          frio, calor, recup, sale_bajo, sale_alto;

        assign t       = temp_entrada[i*W +: W];
        assign frio    = (t < T_MIN_C);
        assign calor   = (t > T_MAX_C);
        assign cnt_inc = cnt_q + CNT_ONE;

`ifdef MONITOREO_HISTERESIS_EN
        assign recup     = (t >= REC_LO_C) && (t <= REC_HI_C);
        assign sale_bajo = (t >= REC_LO_C);
        assign sale_alto = (t <= REC_HI_C);
`else
        assign recup     = !frio && !calor;
        assign sale_bajo = 1'b1;
        assign sale_alto = 1'b1;
`endif

        // Next-state, counter and direction for this channel.
        always_comb begin
            // NOTE: every variable gets a default first so no path can infer a latch.
            estado_d = estado_q;
            cnt_d    = cnt_q;
            dir_d    = dir_q;
            if (!canal_en[i]) begin
                estado_d = NORMAL;
                cnt_d    = '0;
                dir_d    = 1'b0;
            end else if (valido[i]) begin
                unique case (estado_q)
                    NORMAL: begin
                        if (frio || calor) begin
                            if (N_PERS == 1) begin
                                estado_d = ALERTA;
                                cnt_d    = '0;
                                dir_d    = calor;
                            end else begin
                                estado_d = frio ? BAJO : ALTO;
                                cnt_d    = CNT_ONE;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    BAJO: begin
                        if (frio) begin
                            if (cnt_inc == PERS_C) begin
                                estado_d = ALERTA;
                                cnt_d    = '0;
                                dir_d    = 1'b0;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else if (calor) begin
                            estado_d = ALTO;
                            cnt_d    = CNT_ONE;
                        end else if (sale_bajo) begin
                            estado_d = NORMAL;
                            cnt_d    = '0;
                        end
                    end
                    ALTO: begin
                        if (calor) begin
                            if (cnt_inc == PERS_C) begin
                                estado_d = ALERTA;
                                cnt_d    = '0;
                                dir_d    = 1'b1;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else if (frio) begin
                            estado_d = BAJO;
                            cnt_d    = CNT_ONE;
                        end else if (sale_alto) begin
                            estado_d = NORMAL;
                            cnt_d    = '0;
                        end
                    end
                    ALERTA: begin
                        if (recup) begin
                            if (cnt_inc == RECU_C) begin
                                estado_d = NORMAL;
                                cnt_d    = '0;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else if ((dir_q && frio) || (!dir_q && calor)) begin
                            dir_d = !dir_q;
                            cnt_d = '0;
                        end else begin
                            cnt_d = '0;
                        end
                    end
                endcase
            end
        end

        // Channel registers with synchronous reset.
        always_ff @(posedge clk) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (rst) begin
                estado_q <= NORMAL;
                cnt_q    <= '0;
                dir_q    <= 1'b0;
            end else begin
                estado_q <= estado_d;
                cnt_q    <= cnt_d;
                dir_q    <= dir_d;
            end
        end

        assign entra_alerta[i]               = (estado_d == ALERTA) && (estado_q != ALERTA);
        assign estado_actual[2*i +: 2]       = estado_q;
        assign contador_salida[i*CW +: CW]   = cnt_q;
        assign alerta[i]                     = (estado_q == ALERTA);
        assign calefactor[i]                 = (estado_q == BAJO) || ((estado_q == ALERTA) && !dir_q);
        assign ventilador[i]                 = (estado_q == ALTO) || ((estado_q == ALERTA) && dir_q);
    end

    assign alerta_global = |alerta;

    // Sticky alert latch: a new alert on any channel wins over a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            alerta_sticky <= 1'b0;
        end else if (|entra_alerta) begin
            alerta_sticky <= 1'b1;
        end else if (borrar_sticky) begin
            alerta_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Testbench for monitoreo_multicanal: directed test-plan sequences followed
// by randomized traffic, all checked through a scoreboard queue filled from a
// behavioural channel model and drained by an independent monitor process.
module tb_monitoreo_multicanal;

    localparam int N_CH   = 4;
    localparam int W      = 10;
    localparam int T_MIN  = 180;
    localparam int T_MAX  = 259;
    localparam int N_PERS = 6;
    localparam int N_RECU = 1;
    localparam int HIST   = 5;
    localparam int CW     = $clog2(((N_PERS > N_RECU) ? N_PERS : N_RECU) + 1);

    // Channel condition names for the model.
    localparam int M_NORMAL = 0;
    localparam int M_BAJO   = 1;
    localparam int M_ALTO   = 2;
    localparam int M_ALERTA = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_CH*W-1:0]   temp_entrada = '0;
    logic [N_CH-1:0]     valido = '0;
    logic [N_CH-1:0]     canal_en = '1;
    logic                borrar_sticky = 1'b0;
    logic [2*N_CH-1:0]   estado_actual;
    logic [N_CH*CW-1:0]  contador_salida;
    logic [N_CH-1:0]     alerta, calefactor, ventilador;
    logic                alerta_global, alerta_sticky;

    monitoreo_multicanal #(
        .N_CH(N_CH), .W(W), .T_MIN(T_MIN), .T_MAX(T_MAX),
        .N_PERS(N_PERS), .N_RECU(N_RECU), .HIST(HIST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .temp_entrada(temp_entrada),
        .valido(valido),
        .canal_en(canal_en),
        .borrar_sticky(borrar_sticky),
        .estado_actual(estado_actual),
        .contador_salida(contador_salida),
        .alerta(alerta),
        .calefactor(calefactor),
        .ventilador(ventilador),
        .alerta_global(alerta_global),
        .alerta_sticky(alerta_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*N_CH-1:0]  est;
        logic [N_CH*CW-1:0] cnt;
        logic [N_CH-1:0]    al;
        logic [N_CH-1:0]    ca;
        logic [N_CH-1:0]    ve;
        logic               ag;
        logic               st;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model: condition, run length and alert side per channel.
    int m_cond[N_CH];
    int m_run[N_CH];
    int m_hot[N_CH];
    int m_sticky;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    function automatic bit in_recovery(input int t);
`ifdef MONITOREO_HISTERESIS_EN
        return (t >= T_MIN + HIST) && (t <= T_MAX - HIST);
`else
        return (t >= T_MIN) && (t <= T_MAX);
`endif
    endfunction

    function automatic bit may_leave_bajo(input int t);
`ifdef MONITOREO_HISTERESIS_EN
        return t >= T_MIN + HIST;
`else
        return t >= T_MIN;
`endif
    endfunction

    function automatic bit may_leave_alto(input int t);
`ifdef MONITOREO_HISTERESIS_EN
        return t <= T_MAX - HIST;
`else
        return t <= T_MAX;
`endif
    endfunction

    // Advance the model by one clock edge given the inputs presented before it.
    task automatic model_step(input logic [N_CH*W-1:0] temps, input logic [N_CH-1:0] v,
                              input logic [N_CH-1:0] en, input logic bs, input logic r);
        bit any_new_alert;
        any_new_alert = 0;
        if (r) begin
            for (int c = 0; c < N_CH; c++) begin
                m_cond[c] = M_NORMAL; m_run[c] = 0; m_hot[c] = 0;
            end
            m_sticky = 0;
            return;
        end
        for (int c = 0; c < N_CH; c++) begin
            int t;
            bit cold, hot;
            t = int'(temps[c*W +: W]);
            cold = t < T_MIN;
            hot  = t > T_MAX;
            if (!en[c]) begin
                m_cond[c] = M_NORMAL; m_run[c] = 0; m_hot[c] = 0;
                continue;
            end
            if (!v[c]) continue;
            if (m_cond[c] == M_ALERTA) begin
                if (in_recovery(t)) begin
                    m_run[c]++;
                    if (m_run[c] >= N_RECU) begin
                        m_cond[c] = M_NORMAL; m_run[c] = 0;
                    end
                end else begin
                    if ((m_hot[c] == 1 && cold) || (m_hot[c] == 0 && hot))
                        m_hot[c] = 1 - m_hot[c];
                    m_run[c] = 0;
                end
            end else if (cold || hot) begin
                // Extend a run of the same extreme, otherwise start a new one.
                if ((cold && m_cond[c] == M_BAJO) || (hot && m_cond[c] == M_ALTO))
                    m_run[c]++;
                else
                    m_run[c] = 1;
                if (m_run[c] >= N_PERS) begin
                    m_cond[c] = M_ALERTA; m_run[c] = 0; m_hot[c] = hot;
                    any_new_alert = 1;
                end else begin
                    m_cond[c] = cold ? M_BAJO : M_ALTO;
                end
            end else begin
                // In-range sample: drop back unless the hysteresis margin holds it.
                if (m_cond[c] == M_NORMAL ||
                    (m_cond[c] == M_BAJO && may_leave_bajo(t)) ||
                    (m_cond[c] == M_ALTO && may_leave_alto(t))) begin
                    m_cond[c] = M_NORMAL; m_run[c] = 0;
                end
            end
        end
        if (any_new_alert) m_sticky = 1;
        else if (bs)       m_sticky = 0;
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.est = '0; e.cnt = '0; e.al = '0; e.ca = '0; e.ve = '0;
        for (int c = 0; c < N_CH; c++) begin
            e.est[2*c +: 2]   = 2'(m_cond[c]);
            e.cnt[c*CW +: CW] = CW'(m_run[c]);
            e.al[c] = (m_cond[c] == M_ALERTA);
            e.ca[c] = (m_cond[c] == M_BAJO) || (m_cond[c] == M_ALERTA && m_hot[c] == 0);
            e.ve[c] = (m_cond[c] == M_ALTO) || (m_cond[c] == M_ALERTA && m_hot[c] == 1);
        end
        e.ag = |e.al;
        e.st = (m_sticky != 0);
        return e;
    endfunction

    // Drive one cycle of stimulus and queue what the DUT must show after the edge.
    task automatic step(input logic [N_CH*W-1:0] temps, input logic [N_CH-1:0] v,
                        input logic [N_CH-1:0] en, input logic bs, input logic r);
        temp_entrada  = temps;
        valido        = v;
        canal_en      = en;
        borrar_sticky = bs;
        rst           = r;
        model_step(temps, v, en, bs, r);
        @(posedge clk);
        #1;
        sb_q.push_back(model_outputs());
    endtask

    function automatic logic [N_CH*W-1:0] temps4(input int t0, input int t1, input int t2, input int t3);
        logic [N_CH*W-1:0] r;
        r = '0;
        r[0*W +: W] = W'(t0);
        r[1*W +: W] = W'(t1);
        r[2*W +: W] = W'(t2);
        r[3*W +: W] = W'(t3);
        return r;
    endfunction

    // Monitor: compare every queued expectation against the DUT away from the edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("estado_actual",   32'(estado_actual),   32'(e.est));
            check("contador_salida", 32'(contador_salida), 32'(e.cnt));
            check("alerta",          32'(alerta),          32'(e.al));
            check("calefactor",      32'(calefactor),      32'(e.ca));
            check("ventilador",      32'(ventilador),      32'(e.ve));
            check("alerta_global",   32'(alerta_global),   32'(e.ag));
            check("alerta_sticky",   32'(alerta_sticky),   32'(e.st));
        end
    end

    initial begin
        int base[N_CH];
        logic [N_CH*W-1:0] idle;
        idle = temps4(220, 220, 220, 220);

        // Reset for two cycles.
        step(idle, '0, 4'b1111, 1'b0, 1'b1);
        step(idle, '0, 4'b1111, 1'b0, 1'b1);

        // Hot persistence on ch0.
        for (int k = 0; k < 6; k++) step(temps4(300, 220, 220, 220), 4'b0001, 4'b1111, 1'b0, 1'b0);

        // Cold transient on ch1.
        for (int k = 0; k < 3; k++) step(temps4(220, 150, 220, 220), 4'b0010, 4'b1111, 1'b0, 1'b0);
        step(idle, 4'b0010, 4'b1111, 1'b0, 1'b0);

        // Cold alert and recovery on ch2.
        for (int k = 0; k < 6; k++) step(temps4(220, 220, 170, 220), 4'b0100, 4'b1111, 1'b0, 1'b0);
        step(temps4(220, 220, 182, 220), 4'b0100, 4'b1111, 1'b0, 1'b0);
        step(temps4(220, 220, 185, 220), 4'b0100, 4'b1111, 1'b0, 1'b0);

        // Gapped valid samples on ch3, then enable drop mid-count.
        for (int k = 0; k < 11; k++)
            step(temps4(220, 220, 220, 160), (k % 2 == 0) ? 4'b1000 : 4'b0000, 4'b1111, 1'b0, 1'b0);
        step(idle, '0, 4'b0111, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++)
            step(temps4(220, 220, 220, 160), (k % 2 == 0) ? 4'b1000 : 4'b0000, 4'b1111, 1'b0, 1'b0);
        step(temps4(220, 220, 220, 160), 4'b1000, 4'b0111, 1'b0, 1'b0);
        step(idle, '0, 4'b1111, 1'b0, 1'b0);

        // Sticky race: clear, recover ch0, re-alert with a simultaneous clear, then clear.
        step(temps4(220, 220, 220, 220), 4'b0001, 4'b1111, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(temps4(300, 220, 220, 220), 4'b0001, 4'b1111, 1'b0, 1'b0);
        step(temps4(300, 220, 220, 220), 4'b0001, 4'b1111, 1'b1, 1'b0);
        step(idle, '0, 4'b1111, 1'b1, 1'b0);
        step(idle, '0, 4'b1111, 1'b0, 1'b0);

        // Randomized traffic around the thresholds, with occasional reset/enable/clear.
        for (int c = 0; c < N_CH; c++) base[c] = 220;
        for (int k = 0; k < 600; k++) begin
            logic [N_CH*W-1:0] tt;
            logic [N_CH-1:0]   v, en;
            logic              bs, r;
            tt = '0;
            for (int c = 0; c < N_CH; c++) begin
                int t;
                if (k % 20 == 0) begin
                    case ($urandom_range(0, 4))
                        0: base[c] = 150;
                        1: base[c] = 182;
                        2: base[c] = 220;
                        3: base[c] = 257;
                        default: base[c] = 300;
                    endcase
                end
                if ($urandom_range(0, 9) == 0) t = int'($urandom_range(0, 1023));
                else t = base[c] + int'($urandom_range(0, 16)) - 8;
                tt[c*W +: W] = W'(t);
            end
            v  = N_CH'($urandom | $urandom);
            en = ($urandom_range(0, 19) == 0) ? N_CH'($urandom) : '1;
            bs = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 99) == 0);
            step(tt, v, en, bs, r);
        end

        // Let the monitor drain, bounded.
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/monitoreo_multicanal.md
# monitoreo_multicanal

Parametrised N-channel temperature supervisor, the successor to the single-channel `monitoreo_top`. Each channel runs its own classification FSM (NORMAL/BAJO/ALTO/ALERTA) with programmable persistence before alert and before recovery. Channels also have a per-channel enable and a valid strobe. The block drives per-channel heater/fan/alert outputs plus a global alert and a sticky alert latch for the system controller.

## Interface
- `N_CH`, 4: number of channels.
- `W`, 10: temperature sample width, unsigned.
- `T_MIN`, 180: samples below this are cold (frio).
- `T_MAX`, 259: samples above this are hot (calor).
- `N_PERS`, 6: consecutive out-of-range valid samples needed to enter ALERTA (≥1).
- `N_RECU`, 1: consecutive recovery-zone valid samples needed to leave ALERTA (≥1).
- `HIST`, 5: hysteresis margin, used only with the macro. Constraint: 2·HIST < T_MAX−T_MIN.
- Localparam `CW` = $clog2(max(N_PERS,N_RECU)+1).
- Ports:
- `clk`  in  1  clock, all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `temp_entrada`  in  N_CH·W  channel i at bits [i·W +: W].
- `valido`  in  N_CH  sample strobe per channel.
- `canal_en`  in  N_CH  channel enable.
- `borrar_sticky`  in  1  clears `alerta_sticky`.
- `estado_actual`  out  2·N_CH  per channel: 00 NORMAL, 01 BAJO, 10 ALTO, 11 ALERTA.
- `contador_salida`  out  N_CH·CW  per-channel persistence/recovery counter.
- `alerta`, `calefactor`, `ventilador`  out  N_CH each  per-channel actuators.
- `alerta_global`  out  1  OR of `alerta`.
- `alerta_sticky`  out  1  latched alert.

## Operation
- A sample is *active* when `valido[i] && canal_en[i]`. A non-active cycle holds state, counter, and dir.
- `canal_en[i]=0`: channel is forced to NORMAL, with counter 0 and dir 0, at the next edge.
- Sample classes: frio if t<T_MIN; calor if t>T_MAX; otherwise normal.
- NORMAL:
  - frio → BAJO, cnt=1.
  - calor → ALTO, cnt=1.
  - If N_PERS=1, either frio or calor goes straight to ALERTA, with dir set (0 = cold, 1 = hot).
  - normal → stays NORMAL, cnt=0.
- BAJO:
  - frio → cnt+1; when cnt+1==N_PERS, enter ALERTA with dir=0 and cnt=0.
  - calor → ALTO, cnt=1.
  - normal → NORMAL, cnt=0.
- ALTO: mirror of BAJO, entering ALERTA with dir=1.
- ALERTA:
  - Recovery-zone sample → cnt+1; when cnt+1==N_RECU, go to NORMAL, cnt=0.
  - Opposite-extreme sample → dir flips, cnt=0.
  - Any other sample → cnt=0.
- Recovery zone without the macro: normal class.
- Decoded outputs:
  - `alerta[i]` = (state==ALERTA).
  - `calefactor[i]` = BAJO, or ALERTA with dir=0.
  - `ventilador[i]` = ALTO, or ALERTA with dir=1.
- `alerta_sticky`:
  - Set at any edge where some channel enters ALERTA.
  - Cleared by `borrar_sticky`.
  - Set wins when both happen on the same edge.

## Timing
- State, counter, dir, and sticky are registers. All outputs are combinational decode of registers (no extra pipeline).
- Sample presented before edge k → its effect is visible on outputs right after edge k (1-cycle latency).
- With defaults, the 6th consecutive active hot sample sets `alerta` at that same edge.
- Reset (`rst` high at an edge) values:
  - All states NORMAL, all counters 0, all dir 0, `alerta_sticky` 0.
  - Hence all outputs are 0.
  - Reset overrides every other input, including mid-count and in ALERTA.
- Channels are fully independent. Simultaneous alerts on several channels each set their own bit. Sticky is set once.
- Counter never exceeds max(N_PERS,N_RECU)−1; no wrap.

## Configuration
- `MONITOREO_HISTERESIS_EN` defined:
  - Recovery zone is T_MIN+HIST ≤ t ≤ T_MAX−HIST.
  - BAJO→NORMAL requires t ≥ T_MIN+HIST; otherwise BAJO holds and cnt is unchanged.
  - ALTO→NORMAL requires t ≤ T_MAX−HIST; otherwise ALTO holds and cnt is unchanged.
- Undefined: `HIST` is ignored; the recovery zone equals the normal class.

## Test plan
- Reset: `rst`=1 for 2 cycles, all temps 220, `canal_en`=all 1s → every `estado_actual`=00, counters 0, all alert/actuator outputs 0, sticky 0.
- Hot persistence on ch0: 300 with `valido` for 6 cycles:
  - After samples 1–5: state 10, counter 1..5, `ventilador[0]`=1.
  - After sample 6: state 11, `alerta[0]`=1, `alerta_global`=1, `alerta_sticky`=1, counter 0.
- Transient on ch1: 150 ×3 then 220 → state 01 with counter 1,2,3, then 00/0; `alerta[1]` never asserts.
- Recovery on ch2: 170 ×6 (ALERTA, `calefactor[2]`=1), then 182:
  - With macro: stays 11.
  - Without macro: 00.
  - Then 185 → 00 in both builds.
- Gaps/enable on ch3: 160 with `valido` on alternate cycles → ALERTA after the 6th valid sample (11th cycle). Repeat with `canal_en[3]` dropped after 3 samples → 00, counter 0 next edge.
- Sticky race: `borrar_sticky`=1 on the same edge ch0 enters ALERTA → sticky stays 1. Clear on a later idle edge → 0.
